// File: rtl/kd_tree_pkg.sv
// Shared types, widths and level-parity helpers for the kd-tree clustering datapath.
package kd_tree_pkg;

    localparam int pkg_dim        = 3;
    localparam int pkg_data_range = 255;
    localparam int pkg_max_n      = 1000;
    localparam int pkg_max_depth  = 4;

    localparam int dim_size     = $clog2(pkg_dim + 1);
    localparam int center_size  = $clog2(pkg_data_range + 1);
    localparam int counter_size = $clog2(pkg_max_n);
    localparam int depth_size   = $clog2(pkg_max_depth);
    localparam int axis_size    = $clog2(pkg_dim);

    typedef enum logic [2:0] {
        IDLE,
        SORT_EVEN,
        SORT_ODD,
        PROPAGATE,
        DRAIN,
        DONE
    } kd_ctrl_state_t;

    // The leaf depth has no children to swap with, so it never takes part in a sort pass.
    function automatic logic [31:0] even_level_mask(input int depth);
        logic [31:0] m;
        for (int d = 0; d < 32; d++) m[d] = (d < depth - 1) && (d % 2 == 0);
        return m;
    endfunction

    function automatic logic [31:0] odd_level_mask(input int depth);
        logic [31:0] m;
        for (int d = 0; d < 32; d++) m[d] = (d < depth - 1) && (d % 2 == 1);
        return m;
    endfunction

endpackage

// File: rtl/kd_level_pipe.sv
// Per-level valid shift register tracking points as they descend the kd-tree.
module kd_level_pipe
    import kd_tree_pkg::*;
#(
    parameter int max_depth = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 shift_in,
    output logic [max_depth-1:0] lv,
    output logic                 empty_next
);

    always_ff @(posedge clk) begin
        if (rst) lv <= '0;
        else     lv <= {lv[max_depth-2:0], shift_in};
    end

    // True when the tree will hold no point after this edge, letting DRAIN leave one cycle early.
    assign empty_next = !shift_in && (lv[max_depth-2:0] == '0);

endmodule

// File: rtl/kd_sort_controller.sv
// Sort/propagate sequencer for the kd-tree node array.
// Optional pass-limit watchdog enabled by defining KD_CTRL_TIMEOUT_EN.
module kd_sort_controller
    import kd_tree_pkg::*;
#(
    parameter int dim        = 3,
    parameter int data_range = 255,
    parameter int max_n      = 1000,
    parameter int max_depth  = 4,
    parameter int max_passes = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [$clog2(max_n)-1:0] n_points,
    input  logic [max_depth-1:0]     node_switch,
    input  logic                     point_valid,
    output logic                     point_ready,
    output logic                     sorting,
    output logic [max_depth-1:0]     level_en,
    output logic                     receive_point,
    output logic [max_depth-1:0]     next_level,
    output logic                     inc,
    output logic                     busy,
    output logic                     sort_done,
    output logic                     done,
    output logic                     error
);

    localparam int cnt_w = $clog2(max_n);
    localparam logic [max_depth-1:0] even_mask = max_depth'(even_level_mask(max_depth));
    localparam logic [max_depth-1:0] odd_mask  = max_depth'(odd_level_mask(max_depth));

    kd_ctrl_state_t state, state_next;
    logic [cnt_w-1:0] n_cap, accepted;
    logic [1:0] quiet, quiet_next;
    logic any_sw, handshake, empty_next, timeout;
    logic [max_depth-1:0] lv;

`ifdef KD_CTRL_TIMEOUT_EN
    localparam int pass_size = $clog2(max_passes) + 1;
    logic [pass_size-1:0] pass_cnt;
`endif

    always_comb begin
        state_next  = state;
        quiet_next  = quiet;
        level_en    = '0;
        sorting     = 1'b0;
        point_ready = 1'b0;
        done        = 1'b0;
        any_sw      = 1'b0;
        timeout     = 1'b0;
        case (state)
            IDLE: if (start) state_next = SORT_EVEN;
            SORT_EVEN, SORT_ODD: begin
                sorting    = 1'b1;
                level_en   = (state == SORT_EVEN) ? even_mask : odd_mask;
                any_sw     = |(node_switch & level_en);
                quiet_next = any_sw ? 2'd0 : ((quiet == 2'd2) ? 2'd2 : quiet + 2'd1);
                if (quiet_next == 2'd2) state_next = PROPAGATE;
`ifdef KD_CTRL_TIMEOUT_EN
                else if (pass_cnt == pass_size'(max_passes - 1)) begin
                    state_next = DONE;
                    timeout    = 1'b1;
                end
`endif
                else state_next = (state == SORT_EVEN) ? SORT_ODD : SORT_EVEN;
            end
            PROPAGATE: begin
                point_ready = (accepted < n_cap);
                if ((accepted == n_cap) || (point_valid && point_ready && (accepted + 1'b1 == n_cap)))
                    state_next = DRAIN;
            end
            DRAIN: if (empty_next) state_next = DONE;
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign handshake     = point_valid && point_ready;
    assign receive_point = handshake;
    assign next_level    = lv;
    assign inc           = lv[max_depth-1];
    assign busy          = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            n_cap     <= '0;
            accepted  <= '0;
            quiet     <= '0;
            sort_done <= 1'b0;
        end else begin
            state <= state_next;
            quiet <= quiet_next;
            if (state == IDLE && start) begin
                n_cap    <= n_points;
                accepted <= '0;
                quiet    <= '0;
            end
            if (handshake) accepted <= accepted + 1'b1;
            if (state_next == PROPAGATE)  sort_done <= 1'b1;
            else if (state_next == IDLE)  sort_done <= 1'b0;
        end
    end

`ifdef KD_CTRL_TIMEOUT_EN
    // Error is sticky across DONE/IDLE so the sequencer can read it after the run ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            pass_cnt <= '0;
            error    <= 1'b0;
        end else if (state == IDLE && start) begin
            pass_cnt <= '0;
            error    <= 1'b0;
        end else if (sorting) begin
            pass_cnt <= pass_cnt + 1'b1;
            if (timeout) error <= 1'b1;
        end
    end
`else
    assign error = 1'b0;
`endif

    kd_level_pipe #(.max_depth(max_depth)) u_level_pipe (
        .clk       (clk),
        .rst       (rst),
        .shift_in  (handshake),
        .lv        (lv),
        .empty_next(empty_next)
    );

endmodule

// File: tb/tb_kd_sort_controller.sv
// Scoreboard bench for kd_sort_controller: randomized runs checked against a sequence-level reference model.
module tb_kd_sort_controller;

    localparam int MAXD = 4;
    localparam int MAXP = 16;
    localparam int NW   = 10;

    typedef struct {
        int cycle;
        bit err;
    } done_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [NW-1:0] n_points = '0;
    logic [MAXD-1:0] node_switch = '0;
    logic point_valid = 1'b0;
    logic point_ready, sorting, receive_point, inc, busy, sort_done, done, error;
    logic [MAXD-1:0] level_en, next_level;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    logic [MAXD-1:0] exp_level_q[$];
    int exp_rx_q[$];
    int exp_inc_q[$];
    done_t exp_done_q[$];
    bit hs_mark [0:131071];

    kd_sort_controller dut (
        .clk(clk), .rst(rst), .start(start), .n_points(n_points),
        .node_switch(node_switch), .point_valid(point_valid), .point_ready(point_ready),
        .sorting(sorting), .level_en(level_en), .receive_point(receive_point),
        .next_level(next_level), .inc(inc), .busy(busy), .sort_done(sort_done),
        .done(done), .error(error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
        end
    endtask

    // A pass at index p is even or odd; only non-leaf depths of matching parity take part.
    function automatic logic [MAXD-1:0] mask_for(input int p);
        logic [MAXD-1:0] m;
        m = '0;
        for (int d = 0; d < MAXD - 1; d++) if ((d % 2) == (p % 2)) m[d] = 1'b1;
        return m;
    endfunction

    function automatic bit mark_at(input int x);
        return (x >= 0) ? hs_mark[x] : 1'b0;
    endfunction

    // Scoreboard monitor: every output event must match the oldest expectation of its kind.
    always @(negedge clk) begin
        if (!rst) begin
            if (sorting) begin
                if (exp_level_q.size() == 0) checkOutput("sort_unexpected", 1, 0);
                else checkOutput("level_en", int'(level_en), int'(exp_level_q.pop_front()));
            end
            if (receive_point) begin
                if (exp_rx_q.size() == 0) checkOutput("receive_unexpected", 1, 0);
                else checkOutput("receive_cycle", cyc, exp_rx_q.pop_front());
            end
            if (inc) begin
                if (exp_inc_q.size() == 0) checkOutput("inc_unexpected", 1, 0);
                else checkOutput("inc_cycle", cyc, exp_inc_q.pop_front());
            end
            if (done) begin
                if (exp_done_q.size() == 0) checkOutput("done_unexpected", 1, 0);
                else begin
                    done_t e;
                    e = exp_done_q.pop_front();
                    checkOutput("done_cycle", cyc, e.cycle);
                    checkOutput("done_error", int'(error), int'(e.err));
                end
            end
        end
    end

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_busy"}, int'(busy), 0);
        checkOutput({tag, "_sorting"}, int'(sorting), 0);
        checkOutput({tag, "_level_en"}, int'(level_en), 0);
        checkOutput({tag, "_ready"}, int'(point_ready), 0);
        checkOutput({tag, "_receive"}, int'(receive_point), 0);
        checkOutput({tag, "_next_level"}, int'(next_level), 0);
        checkOutput({tag, "_inc"}, int'(inc), 0);
        checkOutput({tag, "_sort_done"}, int'(sort_done), 0);
        checkOutput({tag, "_done"}, int'(done), 0);
        checkOutput({tag, "_error"}, int'(error), 0);
    endtask

    // One run: sw_passes passes carry switch patterns (bit 0 only, or random), then the tree is clean.
    // vmode: 0 continuous valid, 1 alternating, 2 random. abort_k > 0 asserts rst in that run cycle.
    task automatic applyStimulus(input int n, input int sw_passes, input bit ns0_only,
                                 input int vmode, input bit stuck, input int abort_k);
        logic [MAXD-1:0] pat [0:127];
        bit clean [0:127];
        logic [MAXD-1:0] exp_next;
        int sorts, c, acc, done_cyc, t;
        bit timeout, hs, exp_ready;

        for (int p = 0; p < 128; p++) begin
            if (stuck) pat[p] = '1;
            else if (p < sw_passes) pat[p] = ns0_only ? MAXD'(1) : MAXD'($urandom);
            else pat[p] = '0;
            clean[p] = ((pat[p] & mask_for(p)) == '0);
        end
        sorts = 1000;
        for (int p = 1; p < 128; p++) begin
            if (clean[p-1] && clean[p]) begin
                sorts = p + 1;
                break;
            end
        end
        timeout = 1'b0;
`ifdef KD_CTRL_TIMEOUT_EN
        if (sorts > MAXP) begin
            sorts = MAXP;
            timeout = 1'b1;
        end
`endif

        @(posedge clk); #1;
        c = cyc;
        start = 1'b1;
        n_points = NW'(n);
        node_switch = MAXD'($urandom);
        point_valid = 1'($urandom);
        #1;
        checkOutput("idle_busy", int'(busy), 0);
        checkOutput("idle_ready", int'(point_ready), 0);
        for (int p = 0; p < ((sorts < 128) ? sorts : 128); p++) exp_level_q.push_back(mask_for(p));
        acc = 0;
        done_cyc = -1;
        if (timeout) begin
            done_cyc = c + sorts + 1;
            exp_done_q.push_back('{done_cyc, 1'b1});
        end

        for (int k = 1; k < 3000; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            t = cyc;
            if (k == abort_k) begin
                rst = 1'b1;
                point_valid = 1'b0;
                node_switch = '0;
                @(posedge clk); #1;
                rst = 1'b0;
                #1;
                checkAllZero("after_abort");
                exp_level_q.delete();
                exp_rx_q.delete();
                exp_inc_q.delete();
                exp_done_q.delete();
                for (int x = t - MAXD - 1; x <= t + 1; x++) if (x >= 0) hs_mark[x] = 1'b0;
                return;
            end
            node_switch = (k <= sorts && k <= 128) ? pat[k-1] : MAXD'($urandom);
            if (vmode == 0)      point_valid = 1'b1;
            else if (vmode == 1) point_valid = ((t % 2) == 0);
            else                 point_valid = 1'($urandom);

            exp_ready = !timeout && (k > sorts) && (acc < n);
            hs = exp_ready && point_valid;
            if (!timeout && k == sorts + 1 && n == 0) begin
                done_cyc = t + 2;
                exp_done_q.push_back('{done_cyc, 1'b0});
            end
            if (hs) begin
                hs_mark[t] = 1'b1;
                exp_rx_q.push_back(t);
                exp_inc_q.push_back(t + MAXD);
                acc++;
                if (acc == n) begin
                    done_cyc = t + MAXD + 1;
                    exp_done_q.push_back('{done_cyc, 1'b0});
                end
            end
            for (int d = 0; d < MAXD; d++) exp_next[d] = mark_at(t - 1 - d);
            #1;
            checkOutput("point_ready", int'(point_ready), int'(exp_ready));
            checkOutput("receive_point", int'(receive_point), int'(hs));
            checkOutput("sorting", int'(sorting), int'(k <= sorts));
            checkOutput("level_en_now", int'(level_en), (k <= sorts) ? int'(mask_for(k-1)) : 0);
            checkOutput("next_level", int'(next_level), int'(exp_next));
            checkOutput("inc", int'(inc), int'(mark_at(t - MAXD)));
            checkOutput("busy", int'(busy), int'(done_cyc < 0 || t <= done_cyc));
            checkOutput("done", int'(done), int'(t == done_cyc));
            checkOutput("sort_done", int'(sort_done),
                        int'(!timeout && k > sorts && (done_cyc < 0 || t <= done_cyc)));
            checkOutput("error", int'(error), int'(timeout && t >= done_cyc));
            if (done_cyc >= 0 && t == done_cyc + 1) break;
        end
        if (!(done_cyc >= 0 && cyc == done_cyc + 1)) checkOutput("run_completed", 0, 1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkAllZero("reset");

        applyStimulus(3, 0, 1'b1, 0, 1'b0, 0);
        applyStimulus(4, 3, 1'b1, 0, 1'b0, 0);
        applyStimulus(2, 0, 1'b0, 1, 1'b0, 0);
        applyStimulus(0, 0, 1'b0, 2, 1'b0, 0);
        for (int r = 0; r < 8; r++)
            applyStimulus(int'($urandom_range(0, 12)), int'($urandom_range(0, 5)), 1'b0, 2, 1'b0, 0);

        applyStimulus(2, 0, 1'b0, 2, 1'b1, 101);
        applyStimulus(8, 0, 1'b0, 0, 1'b0, 6);
        applyStimulus(3, 2, 1'b0, 1, 1'b0, 0);

        repeat (2) @(posedge clk);
        #1;
        checkOutput("level_queue_empty", exp_level_q.size(), 0);
        checkOutput("rx_queue_empty", exp_rx_q.size(), 0);
        checkOutput("inc_queue_empty", exp_inc_q.size(), 0);
        checkOutput("done_queue_empty", exp_done_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/kd_sort_controller.md
# kd_sort_controller

Sequencing controller for the kd-tree array of `cluster_node` instances. It drives the odd/even level-parity sort passes until the tree is stable, then streams data points down the tree one level per cycle. It also generates the per-level control strobes (`sorting`, `next_level`, `receive_point`, `inc`) that the nodes consume. It sits between the top-level k-means sequencer (start, point stream) and the node array.

## Interface
- `dim`, 3, number of dimensions (passed through to package sizing)
- `data_range`, 255, maximum data value
- `max_n`, 1000, maximum points per run; `counter_size = $clog2(max_n)`
- `max_depth`, 4, tree levels (root = depth 0); `depth_size = $clog2(max_depth)`
- `max_passes`, 16, sort-pass limit for the watchdog
- `clk` input 1: single clock, all logic on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: begin a run. Sampled only in IDLE.
- `n_points` input counter_size: points in this run. Captured on `start`.
- `node_switch` input max_depth: OR of `left_switch_out | right_switch_out` of all nodes at each depth, combinational in the cycle their level is enabled.
- `point_valid` input 1, `point_ready` output 1: point-stream handshake.
- `sorting` output 1: high in SORT_EVEN and SORT_ODD.
- `level_en` output max_depth: per-depth node enable during a sort pass.
- `receive_point` output 1: root latches `point_in` this cycle.
- `next_level` output max_depth: bit d means the point at depth d advances this cycle.
- `inc` output 1: a point retired from the leaf level this cycle.
- `busy`, `sort_done`, `done`, `error` output 1: status outputs.

## Operation
- States: IDLE, SORT_EVEN, SORT_ODD, PROPAGATE, DRAIN, DONE.
- IDLE: `start` captures `n_points`, clears the pass counter and the quiet counter, then goes to SORT_EVEN. `start` in any other state is ignored.
- SORT_EVEN: `level_en` sets the bits at even depths below `max_depth-1`. SORT_ODD does the same for odd depths. The leaf depth bit is never set.
- Each sort state lasts exactly 1 cycle. At its closing edge, the controller ANDs `node_switch` with `level_en` and reduces the result to `any_sw`.
- Quiet counter: reset to 0 when `any_sw` = 1, otherwise incremented (saturates at 2).
- When the quiet counter reaches 2, meaning one even pass and one odd pass both had no switch, the FSM goes to PROPAGATE and `sort_done` is set. Otherwise the FSM alternates EVEN↔ODD and increments the pass counter.
- PROPAGATE: `point_ready` = (accepted < captured `n_points`). A handshake is `point_valid & point_ready`.
  - `receive_point` = handshake, combinational in the same cycle.
  - A valid shift register tracks points: `lv[0]` <= handshake, `lv[d]` <= `lv[d-1]`. `next_level` = `lv`.
  - `inc` = `lv[max_depth-1]`.
  - One point is accepted per cycle; bubbles are allowed.
- When accepted reaches `n_points`, the FSM goes to DRAIN with `point_ready` = 0. DRAIN waits until `lv` = 0, then goes to DONE.
- DONE: `done` = 1 for one cycle, then the FSM returns to IDLE. `sort_done` clears in IDLE.
- `n_points` = 0: the sort still runs, then PROPAGATE goes straight to DRAIN and then DONE.
- `busy` = high in every state except IDLE.
- Arithmetic:
  - The accepted and retired counters are counter_size bits wide, unsigned, and never wrap because they are bounded by `n_points`.
  - The pass counter is `$clog2(max_passes)+1` bits wide.

## Timing
- Reset values: all outputs are 0, state = IDLE, `lv` = 0, all counters = 0.
- `rst` mid-operation aborts the run on the next edge. Nodes must be reset together with the controller.
- `start` to the first `sorting` cycle: 1 cycle.
- Minimum sort phase is 2 cycles: an already sorted tree goes EVEN, ODD, then PROPAGATE.
- Point latency: handshake in cycle t gives `inc` in cycle t+max_depth.
- Last handshake to `done`: max_depth+1 cycles.
- `point_valid` may drop at any time without penalty. `point_ready` never depends on `point_valid`.

## Configuration
- `KD_CTRL_TIMEOUT_EN` defined:
  - If the pass counter reaches `max_passes` without convergence, the FSM goes to DONE with `error` = 1.
  - `error` holds until the next `start` or `rst`.
- `KD_CTRL_TIMEOUT_EN` undefined:
  - No pass limit and no timeout logic; `error` is tied to 0.
  - The pass counter is removed from the design.

## Structure
- Shared package `kd_tree_pkg`:
  - State enum `kd_ctrl_state_t`.
  - Width localparams `dim_size`, `center_size`, `counter_size`, `depth_size`, `axis_size`.
  - Parity mask functions for even and odd levels.
- Sub-module `kd_level_pipe`: the `lv` shift register plus the all-empty flag, parameterised by `max_depth`.

## Test plan
- Pre-sorted tree (`node_switch` = 0 always), `start` with `n_points` = 3 → `sorting` high for 2 cycles with `level_en` = 4'b0101 then 4'b0010; `sort_done` in cycle 3.
- `node_switch[0]` = 1 for the first 3 passes → 5 sort cycles; PROPAGATE entered only after two consecutive clean passes.
- `n_points` = 4 with continuous `point_valid` → 4 consecutive `receive_point` cycles; `inc` at t+4..t+7; `done` 5 cycles after the last handshake; `point_ready` = 0 after the 4th handshake.
- `point_valid` toggling every other cycle, `n_points` = 2 → exactly 2 `inc` pulses, each 4 cycles after its handshake.
- `node_switch` stuck at 1, `max_passes` = 16, with `KD_CTRL_TIMEOUT_EN` defined → `done` and `error` after 16 passes. Without the macro, the FSM is still in SORT at cycle 100 and `error` = 0.
- `rst` asserted during PROPAGATE with `lv` non-zero → next cycle all outputs 0 and state IDLE; a new `start` runs a clean cycle.
